// File: rtl/dfd_tt_dbm_pkg.sv
// Shared types and mode helpers for the DFD debug bus mux.
package dfd_tt_dbm_pkg;

  localparam int DBM_MODE_W = 3;

  typedef enum logic [DBM_MODE_W-1:0] {
    MODE_OFF    = 3'b000,
    MODE_FUNC   = 3'b001,
    MODE_ID     = 3'b010,
    MODE_TOGGLE = 3'b011,
    MODE_COUNT  = 3'b100,
    MODE_FREEZE = 3'b101
  } dbm_mode_e;

  // Reserved encodings (110/111) fall through to inactive.
  function automatic logic mode_is_active(input logic [DBM_MODE_W-1:0] m);
    logic act;
    case (m)
      MODE_FUNC, MODE_ID, MODE_TOGGLE, MODE_COUNT, MODE_FREEZE: act = 1'b1;
      default: act = 1'b0;
    endcase
    return act;
  endfunction

  function automatic logic mode_uses_taps(input logic [DBM_MODE_W-1:0] m);
    return (m == MODE_FUNC) || (m == MODE_FREEZE);
  endfunction

endpackage

// File: rtl/dfd_tt_dbm_out_pipe.sv
// Output register chain for the debug bus mux; STAGES = 0 is a plain wire.
module dfd_tt_dbm_out_pipe #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (STAGES == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;
    assign q = d;
  end else begin : g_regs
    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift chain; stage 0 captures the input.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < STAGES; i++) begin
          stage_q[i] <= '0;
        end
      end else begin
        stage_q[0] <= d;
        for (int i = 1; i < STAGES; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign q = stage_q[STAGES-1];
  end

endmodule

// File: rtl/dfd_tt_dbm_ext_mux.sv
// Debug bus mux: lane selection plus ID, toggle, count and freeze-capture modes,
// followed by a configurable output pipeline with a valid qualifier.
module dfd_tt_dbm_ext_mux
  import dfd_tt_dbm_pkg::*;
#(
  parameter int         NUM_INPUT_LANES  = 16,
  parameter int         NUM_OUTPUT_LANES = 8,
  parameter int         LANE_WIDTH       = 8,
  parameter int         MUX_SEL_WIDTH    = 6,
  parameter logic [5:0] DEBUG_MUX_ID     = 6'h0,
  parameter int         OUT_PIPE_STAGES  = 1
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    cfg_wr_en,
  input  logic [5:0]                              cfg_dbm_id,
  input  logic [DBM_MODE_W-1:0]                   cfg_mode,
  input  logic [NUM_OUTPUT_LANES*MUX_SEL_WIDTH-1:0] cfg_mux_sel,
  input  logic                                    trigger_in,
  input  logic [NUM_INPUT_LANES*LANE_WIDTH-1:0]   debug_signals_in,
  output logic [NUM_OUTPUT_LANES*LANE_WIDTH-1:0]  debug_bus_out,
  output logic                                    debug_bus_valid,
  output logic                                    debug_clken,
  output logic                                    dbm_active,
  output logic                                    frozen
);

  localparam int NI    = NUM_INPUT_LANES;
  localparam int NO    = NUM_OUTPUT_LANES;
  localparam int LW    = LANE_WIDTH;
  localparam int SW    = MUX_SEL_WIDTH;
  localparam int BUS_W = NO * LW;

  logic                  accept;
  logic [DBM_MODE_W-1:0] mode_q;
  logic [DBM_MODE_W-1:0] mode_d1;
  logic [NO*SW-1:0]      sel_q;
  logic                  tgl_q;
  logic [LW-1:0]         cnt_q;
  logic                  frozen_q;
  logic [LW-1:0]         hold_q   [NO];
  logic [LW-1:0]         din      [NI];
  logic [LW-1:0]         mux_lane [NO];
  logic [LW-1:0]         id_lane;
  logic [BUS_W-1:0]      stage_data;
  logic                  stage_valid;
  logic [BUS_W:0]        pipe_q;
  logic [BUS_W:0]        pipe_clean;

  assign accept  = cfg_wr_en && (cfg_dbm_id == DEBUG_MUX_ID);
  assign id_lane = LW'(DEBUG_MUX_ID);

  for (genvar n = 0; n < NI; n++) begin : g_din
    assign din[n] = debug_signals_in[n*LW +: LW];
  end

  // Configuration registers; selects only move on writes that use the taps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q  <= MODE_OFF;
      mode_d1 <= MODE_OFF;
      sel_q   <= '0;
    end else begin
      mode_d1 <= mode_q;
      if (accept) begin
        mode_q <= cfg_mode;
        if (mode_uses_taps(cfg_mode)) begin
          sel_q <= cfg_mux_sel;
        end
      end
    end
  end

  // Pattern generators and freeze capture, all keyed off the delayed mode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tgl_q    <= 1'b0;
      cnt_q    <= '0;
      frozen_q <= 1'b0;
      for (int k = 0; k < NO; k++) begin
        hold_q[k] <= '0;
      end
    end else begin
      tgl_q <= (mode_d1 == MODE_TOGGLE) ? ~tgl_q : 1'b0;
      cnt_q <= (mode_d1 == MODE_COUNT) ? cnt_q + LW'(1) : '0;
      if (accept || (mode_d1 != MODE_FREEZE)) begin
        frozen_q <= 1'b0;
      end else if (trigger_in) begin
        frozen_q <= 1'b1;
      end
      for (int k = 0; k < NO; k++) begin
        if (!frozen_q) begin
          hold_q[k] <= mux_lane[k];
        end
      end
    end
  end

  for (genvar k = 0; k < NO; k++) begin : g_lane
    logic [SW-1:0] sel;
    logic [LW-1:0] pattern;
    logic [LW-1:0] lane_mux;
    logic [LW-1:0] lane_out;

    assign sel     = sel_q[k*SW +: SW];
    assign pattern = (k == 0) ? id_lane : '0;

    // Select 0 keeps the lane's own input; 1..NI-NO reach the upper lanes.
    always_comb begin
      lane_mux = '0;
      for (int i = 0; i < NI; i++) begin
        if ((i == k) && (sel == '0)) begin
          lane_mux = lane_mux | din[i];
        end else if ((i >= NO) && (sel == SW'(i - NO + 1))) begin
          lane_mux = lane_mux | din[i];
        end else begin
          lane_mux = lane_mux;
        end
      end
    end

    assign mux_lane[k] = lane_mux;

    always_comb begin
      lane_out = '0;
      case (mode_d1)
        MODE_FUNC:   lane_out = lane_mux;
        MODE_ID:     lane_out = pattern;
        MODE_TOGGLE: lane_out = pattern ^ {LW{tgl_q}};
        MODE_COUNT:  lane_out = cnt_q + LW'(k);
        MODE_FREEZE: lane_out = frozen_q ? hold_q[k] : lane_mux;
        default:     lane_out = '0;
      endcase
    end

    assign stage_data[k*LW +: LW] = lane_out;
  end

  assign stage_valid = mode_is_active(mode_d1);

  dfd_tt_dbm_out_pipe #(
    .WIDTH  (BUS_W + 1),
    .STAGES (OUT_PIPE_STAGES)
  ) u_out_pipe (
    .clk   (clk),
    .reset (reset),
    .d     ({stage_valid, stage_data}),
    .q     (pipe_q)
  );

`ifndef SYNTHESIS
  // Unknown bits on the outgoing bus read as 0 in simulation.
  always_comb begin
    pipe_clean = '0;
    for (int i = 0; i <= BUS_W; i++) begin
      pipe_clean[i] = (pipe_q[i] === 1'b1) ? 1'b1 : 1'b0;
    end
  end
`else
  assign pipe_clean = pipe_q;
`endif

  assign debug_bus_out   = pipe_clean[BUS_W-1:0];
  assign debug_bus_valid = pipe_clean[BUS_W];
  assign debug_clken     = mode_uses_taps(mode_q);
  assign dbm_active      = mode_is_active(mode_q);
  assign frozen          = frozen_q;

endmodule

// File: tb/tb_dfd_tt_dbm_ext_mux.sv
// Scoreboard bench: four mux instances (pipe depths 1/0/3 with ID 0, pipe 1 with ID 0x2A)
// compared every cycle against a behavioural model, plus directed checks from the test plan.
module tb_dfd_tt_dbm_ext_mux;

  logic         clk = 1'b0;
  logic         reset;
  logic         cfg_wr_en;
  logic [5:0]   cfg_dbm_id;
  logic [2:0]   cfg_mode;
  logic [47:0]  cfg_mux_sel;
  logic         trigger_in;
  logic [127:0] din;

  logic [63:0] bus_a, bus_b, bus_c, bus_d;
  logic vld_a, vld_b, vld_c, vld_d;
  logic clk_a, clk_b, clk_c, clk_d;
  logic act_a, act_b, act_c, act_d;
  logic frz_a, frz_b, frz_c, frz_d;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  dfd_tt_dbm_ext_mux #(.DEBUG_MUX_ID(6'h00), .OUT_PIPE_STAGES(1)) u_a (
    .clk(clk), .reset(reset), .cfg_wr_en(cfg_wr_en), .cfg_dbm_id(cfg_dbm_id),
    .cfg_mode(cfg_mode), .cfg_mux_sel(cfg_mux_sel), .trigger_in(trigger_in),
    .debug_signals_in(din), .debug_bus_out(bus_a), .debug_bus_valid(vld_a),
    .debug_clken(clk_a), .dbm_active(act_a), .frozen(frz_a));

  dfd_tt_dbm_ext_mux #(.DEBUG_MUX_ID(6'h00), .OUT_PIPE_STAGES(0)) u_b (
    .clk(clk), .reset(reset), .cfg_wr_en(cfg_wr_en), .cfg_dbm_id(cfg_dbm_id),
    .cfg_mode(cfg_mode), .cfg_mux_sel(cfg_mux_sel), .trigger_in(trigger_in),
    .debug_signals_in(din), .debug_bus_out(bus_b), .debug_bus_valid(vld_b),
    .debug_clken(clk_b), .dbm_active(act_b), .frozen(frz_b));

  dfd_tt_dbm_ext_mux #(.DEBUG_MUX_ID(6'h00), .OUT_PIPE_STAGES(3)) u_c (
    .clk(clk), .reset(reset), .cfg_wr_en(cfg_wr_en), .cfg_dbm_id(cfg_dbm_id),
    .cfg_mode(cfg_mode), .cfg_mux_sel(cfg_mux_sel), .trigger_in(trigger_in),
    .debug_signals_in(din), .debug_bus_out(bus_c), .debug_bus_valid(vld_c),
    .debug_clken(clk_c), .dbm_active(act_c), .frozen(frz_c));

  dfd_tt_dbm_ext_mux #(.DEBUG_MUX_ID(6'h2A), .OUT_PIPE_STAGES(1)) u_d (
    .clk(clk), .reset(reset), .cfg_wr_en(cfg_wr_en), .cfg_dbm_id(cfg_dbm_id),
    .cfg_mode(cfg_mode), .cfg_mux_sel(cfg_mux_sel), .trigger_in(trigger_in),
    .debug_signals_in(din), .debug_bus_out(bus_d), .debug_bus_valid(vld_d),
    .debug_clken(clk_d), .dbm_active(act_d), .frozen(frz_d));

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model; index 0 = ID 0x00 instances, index 1 = ID 0x2A instance.
  logic [2:0]  m_mode [2];
  logic [2:0]  m_d1   [2];
  logic [47:0] m_sel  [2];
  logic        m_tgl  [2];
  logic [7:0]  m_cnt  [2];
  logic        m_frz  [2];
  logic [7:0]  m_hold [2][8];

  function automatic logic [5:0] id_of(input int i);
    return (i == 0) ? 6'h00 : 6'h2A;
  endfunction

  function automatic logic [7:0] lane_in(input int n);
    return din[n*8 +: 8];
  endfunction

  function automatic logic [7:0] model_mux(input int i, input int k);
    logic [5:0] s;
    s = m_sel[i][k*6 +: 6];
    if (s == 6'd0) return lane_in(k);
    if (int'(s) <= 8) return lane_in(8 + int'(s) - 1);
    return 8'h00;
  endfunction

  function automatic logic [64:0] model_out(input int i);
    logic [64:0] r;
    logic [7:0] pat;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      pat = (k == 0) ? {2'b00, id_of(i)} : 8'h00;
      case (m_d1[i])
        3'd1: r[k*8 +: 8] = model_mux(i, k);
        3'd2: r[k*8 +: 8] = pat;
        3'd3: r[k*8 +: 8] = pat ^ {8{m_tgl[i]}};
        3'd4: r[k*8 +: 8] = m_cnt[i] + 8'(k);
        3'd5: r[k*8 +: 8] = m_frz[i] ? m_hold[i][k] : model_mux(i, k);
        default: r[k*8 +: 8] = 8'h00;
      endcase
    end
    r[64] = (m_d1[i] >= 3'd1) && (m_d1[i] <= 3'd5);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 3'd0; m_d1[i] = 3'd0; m_sel[i] = 48'd0;
      m_tgl[i] = 1'b0; m_cnt[i] = 8'd0; m_frz[i] = 1'b0;
      for (int k = 0; k < 8; k++) m_hold[i][k] = 8'h00;
    end
  endtask

  task automatic model_step(input int i);
    logic acc;
    logic [2:0] od1;
    logic ofrz;
    acc  = cfg_wr_en && (cfg_dbm_id == id_of(i));
    od1  = m_d1[i];
    ofrz = m_frz[i];
    for (int k = 0; k < 8; k++) begin
      if (!ofrz) m_hold[i][k] = model_mux(i, k);
    end
    m_tgl[i] = (od1 == 3'd3) ? ~m_tgl[i] : 1'b0;
    m_cnt[i] = (od1 == 3'd4) ? m_cnt[i] + 8'd1 : 8'd0;
    m_frz[i] = acc ? 1'b0 : ((od1 != 3'd5) ? 1'b0 : (trigger_in ? 1'b1 : ofrz));
    m_d1[i]  = m_mode[i];
    if (acc) begin
      m_mode[i] = cfg_mode;
      if ((cfg_mode == 3'd1) || (cfg_mode == 3'd5)) m_sel[i] = cfg_mux_sel;
    end
  endtask

  function automatic logic model_act(input int i);
    return (m_mode[i] >= 3'd1) && (m_mode[i] <= 3'd5);
  endfunction

  function automatic logic model_clken(input int i);
    return (m_mode[i] == 3'd1) || (m_mode[i] == 3'd5);
  endfunction

  // Expected values captured at each edge; popped once they reach the pipe output.
  logic [64:0] q_a [$];
  logic [64:0] q_c [$];
  logic [64:0] q_d [$];

  always @(posedge clk) begin
    logic [64:0] pre0;
    logic [64:0] pre1;
    pre0 = model_out(0);
    pre1 = model_out(1);
    if (reset) begin
      model_reset();
      pre0 = '0;
      pre1 = '0;
      q_a.delete();
      q_c.delete();
      q_d.delete();
      q_c.push_back(65'd0);
      q_c.push_back(65'd0);
    end else begin
      model_step(0);
      model_step(1);
    end
    q_a.push_back(pre0);
    q_c.push_back(pre0);
    q_d.push_back(pre1);
    #2;
    check_val("sb_pipe1", {vld_a, bus_a}, q_a.pop_front());
    check_val("sb_pipe0", {vld_b, bus_b}, model_out(0));
    check_val("sb_pipe3", {vld_c, bus_c}, q_c.pop_front());
    check_val("sb_id2a", {vld_d, bus_d}, q_d.pop_front());
    check_val("sb_side0", {act_a, clk_a, frz_a}, {model_act(0), model_clken(0), m_frz[0]});
    check_val("sb_side1", {act_d, clk_d, frz_d}, {model_act(1), model_clken(1), m_frz[1]});
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_write(input logic [5:0] id, input logic [2:0] mode, input logic [47:0] sel);
    cfg_wr_en   = 1'b1;
    cfg_dbm_id  = id;
    cfg_mode    = mode;
    cfg_mux_sel = sel;
    tick();
    cfg_wr_en   = 1'b0;
  endtask

  // FUNC write from OFF: lane0 <- input lane 8, lane1 <- input lane 1.
  task automatic latency_check();
    do_write(6'h00, 3'd1, 48'h1);
    check_val("clken_next", clk_a, 1'b1);
    check_val("p0_vld_e0", vld_b, 1'b0);
    tick();
    check_val("p0_vld_e1", vld_b, 1'b1);
    check_val("p0_lane0", bus_b[7:0], 8'hA5);
    check_val("p1_vld_e1", vld_a, 1'b0);
    tick();
    check_val("p1_vld_e2", vld_a, 1'b1);
    check_val("p1_lane0", bus_a[7:0], 8'hA5);
    check_val("p1_lane1", bus_a[15:8], 8'h3C);
    check_val("p3_vld_e2", vld_c, 1'b0);
    tick();
    check_val("p3_vld_e3", vld_c, 1'b0);
    tick();
    check_val("p3_vld_e4", vld_c, 1'b1);
    check_val("p3_lane0", bus_c[7:0], 8'hA5);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cfg_wr_en = 1'b0; cfg_dbm_id = 6'h00; cfg_mode = 3'd0;
    cfg_mux_sel = 48'd0; trigger_in = 1'b0;
    for (int n = 0; n < 16; n++) din[n*8 +: 8] = 8'(n * 17);
    din[64 +: 8] = 8'hA5;
    din[8 +: 8]  = 8'h3C;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_val("rst_bus", {vld_a, bus_a}, 65'd0);
    check_val("rst_side", {act_a, clk_a, frz_a}, 3'b000);

    latency_check();

    do_write(6'h05, 3'd0, 48'hFFFF_FFFF_FFFF);
    repeat (4) tick();
    check_val("badid_act", {act_a, clk_a, vld_a}, 3'b111);
    check_val("badid_bus", bus_a[15:0], 16'h3CA5);

    do_write(6'h2A, 3'd3, 48'd0);
    tick(); tick();
    check_val("tgl_0", bus_d, 64'h0000_0000_0000_002A);
    tick();
    check_val("tgl_1", bus_d, 64'hFFFF_FFFF_FFFF_FFD5);
    tick();
    check_val("tgl_2", bus_d, 64'h0000_0000_0000_002A);
    check_val("tgl_other", bus_a[15:0], 16'h3CA5);

    do_write(6'h00, 3'd4, 48'd0);
    tick(); tick();
    check_val("cnt_first", {vld_a, bus_a}, {1'b1, 64'h0706_0504_0302_0100});
    repeat (256) tick();
    check_val("cnt_wrap", {vld_a, bus_a}, {1'b1, 64'h0706_0504_0302_0100});

    do_write(6'h00, 3'd5, 48'h1);
    for (int v = 8'h30; v < 8'h60; v++) begin
      din[64 +: 8] = 8'(v);
      trigger_in   = (v == 8'h40) || (v == 8'h50);
      if (v == 8'h48) check_val("frz_hold", {frz_a, bus_a[7:0]}, {1'b1, 8'h40});
      tick();
    end
    check_val("frz_retrig", {frz_a, bus_a[7:0]}, {1'b1, 8'h40});
    din[64 +: 8] = 8'h77;
    do_write(6'h00, 3'd5, 48'h1);
    check_val("frz_clear", frz_a, 1'b0);
    tick(); tick();
    check_val("frz_resume", bus_a[7:0], 8'h77);

    do_write(6'h00, 3'd3, 48'd0);
    repeat (5) tick();
    #2 reset = 1'b1;
    #1;
    check_val("arst_a", {vld_a, bus_a, act_a, frz_a}, 67'd0);
    check_val("arst_b", {vld_b, bus_b, act_b, frz_b}, 67'd0);
    check_val("arst_c", {vld_c, bus_c, act_c, frz_c}, 67'd0);
    check_val("arst_d", {vld_d, bus_d, act_d, frz_d}, 67'd0);
    tick(); tick();
    reset = 1'b0;
    din[64 +: 8] = 8'hA5;
    tick();
    latency_check();

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/dfd_tt_dbm_ext_mux.md
Name: dfd_tt_dbm_ext_mux

Overview:
Next-generation debug bus mux (DBM) for the DFD debug fabric. It selects NUM_INPUT_LANES byte-lanes onto NUM_OUTPUT_LANES output lanes under per-lane select registers, using the existing static/upper lane encoding. Beyond the previous generation, it adds:
- a 3-bit mode with a pattern-counter mode and a trigger-freeze capture mode;
- a configurable output pipeline depth;
- an output valid qualifier.
It sits between unit debug taps and the debug bus daisy chain, configured by the DBM CSR write path.

Parameters:
- NUM_INPUT_LANES, 16, number of input lanes; must be > NUM_OUTPUT_LANES.
- NUM_OUTPUT_LANES, 8, number of output lanes; range 1..8.
- LANE_WIDTH, 8, bits per lane; must be >= 6.
- MUX_SEL_WIDTH, 6, select field width per output lane; must satisfy 2^MUX_SEL_WIDTH > NUM_INPUT_LANES-NUM_OUTPUT_LANES.
- DEBUG_MUX_ID, 6'h0, DBM identity, compared against cfg_dbm_id.
- OUT_PIPE_STAGES, 1, register stages after the mux; range 0..3.

Ports:
- clk  in  1  clock, ungated inside the block.
- reset  in  1  asynchronous, active-high reset.
- cfg_wr_en  in  1  configuration write strobe.
- cfg_dbm_id  in  6  target DBM ID of the write.
- cfg_mode  in  3  mode to write.
- cfg_mux_sel  in  NUM_OUTPUT_LANES*MUX_SEL_WIDTH  per-lane selects; lane k occupies bits [k*MUX_SEL_WIDTH +: MUX_SEL_WIDTH].
- trigger_in  in  1  freeze trigger.
- debug_signals_in  in  NUM_INPUT_LANES*LANE_WIDTH  probed lanes.
- debug_bus_out  out  NUM_OUTPUT_LANES*LANE_WIDTH  muxed debug bus.
- debug_bus_valid  out  1  output carries mode data.
- debug_clken  out  1  source-side tap clock enable.
- dbm_active  out  1  mode_q is not OFF or reserved.
- frozen  out  1  freeze capture has occurred.

Behaviour:
- Modes:
  - 000 OFF.
  - 001 FUNC.
  - 010 ID.
  - 011 TOGGLE.
  - 100 COUNT.
  - 101 FREEZE.
  - 110/111 reserved; behave as OFF.
- Accept: a write is accepted when cfg_wr_en & (cfg_dbm_id == DEBUG_MUX_ID).
  - mode_q <= cfg_mode on every accepted write.
  - sel_q <= cfg_mux_sel only when an accepted write has cfg_mode of FUNC or FREEZE; otherwise sel_q holds.
  - Writes with a non-matching ID are ignored entirely.
- Sequencing:
  - mode_d1 <= mode_q every cycle.
  - debug_clken = (mode_q == FUNC or FREEZE), combinational, so it leads input use by one cycle.
  - dbm_active is combinational from mode_q.
- Select encoding per output lane k:
  - 0 selects input lane k.
  - n in 1..NUM_INPUT_LANES-NUM_OUTPUT_LANES selects input lane NUM_OUTPUT_LANES+n-1.
  - Any larger n yields 0.
- Stage-0 data, driven from mode_d1:
  - FUNC: mux output.
  - ID: lane0 = DEBUG_MUX_ID zero-extended; all other lanes 0.
  - TOGGLE: ID pattern XOR {LANE_WIDTH{tgl_q}}.
    - tgl_q clears whenever mode_d1 != TOGGLE; otherwise it inverts every cycle.
    - The first TOGGLE cycle therefore shows the ID pattern, and output alternates thereafter.
  - COUNT: lane k = cnt_q + k, modulo 2^LANE_WIDTH.
    - cnt_q is LANE_WIDTH bits; it clears when mode_d1 != COUNT, otherwise increments and wraps at 2^LANE_WIDTH-1 to 0.
  - FREEZE: stage0 = frozen_q ? hold_q : mux output.
    - hold_q <= mux output while !frozen_q.
    - frozen_q sets at the edge where trigger_in = 1 and mode_d1 == FREEZE, so the held value is the mux output sampled at the trigger edge.
    - frozen_q clears when mode_d1 != FREEZE or on any accepted write.
    - trigger_in is ignored in all other modes; further triggers while frozen have no effect.
  - OFF/reserved: all zeros.
- Valid: stage-0 valid = mode_d1 is in {FUNC, ID, TOGGLE, COUNT, FREEZE}.
- Output pipeline: data and valid pass through OUT_PIPE_STAGES registers; with OUT_PIPE_STAGES = 0 they are combinational from stage 0.
- Latency: a write accepted at edge E gives first new-mode output after edge E+1+OUT_PIPE_STAGES.
- An accepted write in the same cycle as a trigger: the write wins, and frozen_q clears.
- Reset (asynchronous, including mid-operation) clears mode_q, mode_d1, sel_q, tgl_q, cnt_q, hold_q, frozen_q and all pipe stages. All outputs are 0 during and after reset until configured.
- Simulation only: X/Z on output bits is forced to 0 under `ifndef SYNTHESIS.

Decomposition:
- dfd_tt_dbm_pkg gains:
  - dbm_mode_e, a 3-bit enum covering the six modes;
  - DBM_MODE_W = 3.
- Sub-module dfd_tt_dbm_out_pipe, parameters WIDTH and STAGES, async active-high reset. It carries {valid, data}; with STAGES = 0 it is a passthrough.
- Selects and the mux stay in the top as a genvar loop per output lane.

Test Plan:
- Reset then write ID=0, mode FUNC, sel lane0=1, lane1=0, with pipe=1 and lane8=0xA5, lane1=0x3C:
  - debug_clken=1 the cycle after the write edge;
  - two edges after the write: out lane0=0xA5, lane1=0x3C, valid=1.
- Write with cfg_dbm_id=5 against DEBUG_MUX_ID=0: mode, sel and outputs are all unchanged.
- TOGGLE with DEBUG_MUX_ID=6'h2A: lane0 sequence 0x2A, 0xD5, 0x2A...; other lanes 0x00, 0xFF, 0x00...
- COUNT on 8 lanes: first cycle lanes 0..7 = 0..7; after 256 cycles the pattern wraps to match.
- FREEZE: stream an incrementing byte on the selected lane, pulse trigger when the sample = 0x40.
  - Output holds 0x40 and frozen=1.
  - A second trigger has no effect.
  - Rewriting FREEZE clears frozen and resumes streaming.
- Assert reset mid-TOGGLE: outputs, valid, frozen and dbm_active all go 0 asynchronously. Repeat across OUT_PIPE_STAGES 0 and 3, checking latency each time.
